// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and owner encodings shared by the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;
endpackage

// File: rtl/arb_grant.sv
// arb_grant: one-hot grant between IFU (bit 0) and LSU (bit 1); on contention the side not granted last wins.
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_t     last,
  output logic [1:0] grant
);
  assign grant[0] = ifu_valid && (!lsu_valid || last == OWN_LSU);
  assign grant[1] = lsu_valid && (!ifu_valid || last == OWN_IFU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed LSU-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic              ifu_rsp_valid_o,
  output logic [31:0]       ifu_rdata_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [3:0]        lsu_wmask_i,
  output logic              lsu_rsp_valid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rdata_i
);
  state_t            state, nxt;
  owner_t            own, last_grant;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic              take, rsp;
  arb_grant u_grant (
    .ifu_valid(ifu_req_valid_i),
    .lsu_valid(lsu_req_valid_i),
    .last     (last_grant),
    .grant    (grant)
  );
  assign take = state == IDLE && !rst && |grant;
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) last_grant <= OWN_IFU;
    else if (take) last_grant <= grant[1] ? OWN_LSU : OWN_IFU;
  end
`else
  // constant IFU as "last" makes arb_grant favour the LSU
  assign last_grant = OWN_IFU;
`endif
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = |grant ? REQ : IDLE;
    else if (state == REQ) nxt = mem_req_ready_i ? WAIT : REQ;
    else nxt = mem_rsp_valid_i ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      own     <= OWN_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        own     <= grant[1] ? OWN_LSU : OWN_IFU;
        addr_q  <= grant[1] ? lsu_addr_i : ifu_addr_i;
        wdata_q <= grant[1] ? lsu_wdata_i : '0;
        wmask_q <= grant[1] ? lsu_wmask_i : '0;
      end
    end
  end
  assign rsp             = state == WAIT && !rst && mem_rsp_valid_i;
  assign ifu_req_ready_o = take && grant[0];
  assign lsu_req_ready_o = take && grant[1];
  assign ifu_rsp_valid_o = rsp && own == OWN_IFU;
  assign lsu_rsp_valid_o = rsp && own == OWN_LSU;
  assign ifu_rdata_o     = rst ? '0 : mem_rdata_i;
  assign lsu_rdata_o     = rst ? '0 : mem_rdata_i;
  assign mem_req_valid_o = state == REQ && !rst;
  assign mem_addr_o      = rst ? '0 : addr_q;
  assign mem_wdata_o     = rst ? '0 : wdata_q;
  assign mem_wmask_o     = rst ? '0 : wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter in its default fixed-priority build.
module tb_mem_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        ifu_req_valid_i = 0, ifu_req_ready_o, ifu_rsp_valid_o;
  logic [31:0] ifu_addr_i = 0, ifu_rdata_o;
  logic        lsu_req_valid_i = 0, lsu_req_ready_o, lsu_rsp_valid_o;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, lsu_rdata_o;
  logic [3:0]  lsu_wmask_i = 0, mem_wmask_o;
  logic        mem_req_valid_o, mem_req_ready_i = 0, mem_rsp_valid_i = 0;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
  int total = 0, bad = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ifu_req_valid_i = 1;
    mem_rdata_i = 32'h1234_5678;
    tick; tick;
    #1;
    total++; if (ifu_req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ifu_ready got=%b exp=0", ifu_req_ready_o); end
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_req_valid_o); end
    total++; if (ifu_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_ifu_rdata got=%h exp=0", ifu_rdata_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
    ifu_req_valid_i = 0;
    mem_rdata_i = 0;
    rst = 0;
    tick;
  endtask

  task automatic test_fetch;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0000; mem_req_ready_i = 1;
    #1;
    total++; if (ifu_req_ready_o !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b exp=1", ifu_req_ready_o); end
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL fetch_mem_valid_early got=%b exp=0", mem_req_valid_o); end
    tick;
    ifu_req_valid_i = 0;
    #1;
    total++; if (mem_req_valid_o !== 1'b1) begin bad++; $display("FAIL fetch_mem_valid got=%b exp=1", mem_req_valid_o); end
    total++; if (mem_addr_o !== 32'h8000_0000) begin bad++; $display("FAIL fetch_mem_addr got=%h exp=80000000", mem_addr_o); end
    total++; if (mem_wmask_o !== 4'h0) begin bad++; $display("FAIL fetch_wmask got=%h exp=0", mem_wmask_o); end
    tick;
    mem_req_ready_i = 0;
    #1;
    total++; if (mem_req_valid_o !== 1'b0 || ifu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL fetch_wait1 got=%b%b exp=00", mem_req_valid_o, ifu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 1; mem_rdata_i = 32'h0000_0413;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b1) begin bad++; $display("FAIL fetch_rsp_valid got=%b exp=1", ifu_rsp_valid_o); end
    total++; if (ifu_rdata_o !== 32'h0000_0413) begin bad++; $display("FAIL fetch_rdata got=%h exp=00000413", ifu_rdata_o); end
    total++; if (lsu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL fetch_lsu_rsp got=%b exp=0", lsu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 0;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL fetch_rsp_once got=%b exp=0", ifu_rsp_valid_o); end
  endtask

  task automatic test_contention;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0040;
    lsu_req_valid_i = 1; lsu_addr_i = 32'h8000_2000; lsu_wdata_i = 32'h0000_00AA; lsu_wmask_i = 4'h3;
    mem_req_ready_i = 1;
    #1;
    total++; if (lsu_req_ready_o !== 1'b1 || ifu_req_ready_o !== 1'b0) begin bad++; $display("FAIL prio_grant got=lsu%b ifu%b exp=lsu1 ifu0", lsu_req_ready_o, ifu_req_ready_o); end
    tick;
    lsu_req_valid_i = 0;
    #1;
    total++; if (mem_addr_o !== 32'h8000_2000 || mem_wmask_o !== 4'h3) begin bad++; $display("FAIL prio_lsu_req got=%h/%h exp=80002000/3", mem_addr_o, mem_wmask_o); end
    total++; if (ifu_req_ready_o !== 1'b0) begin bad++; $display("FAIL prio_busy_ready got=%b exp=0", ifu_req_ready_o); end
    tick;
    mem_rsp_valid_i = 1;
    #1;
    total++; if (lsu_rsp_valid_o !== 1'b1 || ifu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL prio_lsu_rsp got=lsu%b ifu%b exp=lsu1 ifu0", lsu_rsp_valid_o, ifu_rsp_valid_o); end
    total++; if (ifu_req_ready_o !== 1'b0) begin bad++; $display("FAIL prio_wait_ready got=%b exp=0", ifu_req_ready_o); end
    tick;
    mem_rsp_valid_i = 0;
    #1;
    total++; if (ifu_req_ready_o !== 1'b1) begin bad++; $display("FAIL prio_ifu_next got=%b exp=1", ifu_req_ready_o); end
    tick;
    ifu_req_valid_i = 0;
    #1;
    total++; if (mem_addr_o !== 32'h8000_0040 || mem_wmask_o !== 4'h0 || mem_wdata_o !== 32'h0) begin bad++; $display("FAIL prio_ifu_req got=%h/%h/%h exp=80000040/0/0", mem_addr_o, mem_wmask_o, mem_wdata_o); end
    tick;
    mem_req_ready_i = 0; mem_rsp_valid_i = 1;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b1 || lsu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL prio_ifu_rsp got=ifu%b lsu%b exp=ifu1 lsu0", ifu_rsp_valid_o, lsu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 0;
  endtask

  task automatic test_store_stall;
    lsu_req_valid_i = 1; lsu_addr_i = 32'h8000_1000; lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
    mem_req_ready_i = 0;
    #1;
    total++; if (lsu_req_ready_o !== 1'b1) begin bad++; $display("FAIL store_ready got=%b exp=1", lsu_req_ready_o); end
    tick;
    lsu_req_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready_i = (i == 3);
      #1;
      total++;
      if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h8000_1000 || mem_wdata_o !== 32'hDEAD_BEEF || mem_wmask_o !== 4'hF) begin
        bad++; $display("FAIL store_stable[%0d] got=%b %h %h %h exp=1 80001000 deadbeef f", i, mem_req_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
      end
      tick;
    end
    mem_req_ready_i = 0;
    #1;
    total++; if (mem_req_valid_o !== 1'b0 || lsu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL store_wait got=%b%b exp=00", mem_req_valid_o, lsu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 1;
    #1;
    total++; if (lsu_rsp_valid_o !== 1'b1 || ifu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL store_ack got=lsu%b ifu%b exp=lsu1 ifu0", lsu_rsp_valid_o, ifu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 0;
  endtask

  task automatic test_spurious;
    mem_rsp_valid_i = 1; mem_rdata_i = 32'hFFFF_0000;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b0 || lsu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL spur_rsp got=ifu%b lsu%b exp=0 0", ifu_rsp_valid_o, lsu_rsp_valid_o); end
    tick;
    mem_rsp_valid_i = 0;
    #1;
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL spur_mem_valid got=%b exp=0", mem_req_valid_o); end
    ifu_req_valid_i = 1;
    #1;
    total++; if (ifu_req_ready_o !== 1'b1) begin bad++; $display("FAIL spur_still_idle got=%b exp=1", ifu_req_ready_o); end
    ifu_req_valid_i = 0;
    #1;
  endtask

  task automatic test_reset_wait;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0100; mem_req_ready_i = 1;
    tick;
    ifu_req_valid_i = 0;
    tick;
    mem_req_ready_i = 0; rst = 1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    total++; if (mem_req_valid_o !== 1'b0 || ifu_rsp_valid_o !== 1'b0 || ifu_rdata_o !== 32'h0 || mem_addr_o !== 32'h0) begin
      bad++; $display("FAIL rstw_outputs got=%b %b %h %h exp=0 0 0 0", mem_req_valid_o, ifu_rsp_valid_o, ifu_rdata_o, mem_addr_o);
    end
    tick;
    rst = 0; mem_rsp_valid_i = 1;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b0 || lsu_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rstw_dropped got=ifu%b lsu%b exp=0 0", ifu_rsp_valid_o, lsu_rsp_valid_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rstw_addr_clear got=%h exp=0", mem_addr_o); end
    tick;
    mem_rsp_valid_i = 0;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0200; mem_req_ready_i = 1;
    #1;
    total++; if (ifu_req_ready_o !== 1'b1) begin bad++; $display("FAIL rstw_next_ready got=%b exp=1", ifu_req_ready_o); end
    tick;
    ifu_req_valid_i = 0;
    #1;
    total++; if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h8000_0200) begin bad++; $display("FAIL rstw_next_req got=%b %h exp=1 80000200", mem_req_valid_o, mem_addr_o); end
    tick;
    mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'h0000_0013;
    #1;
    total++; if (ifu_rsp_valid_o !== 1'b1 || ifu_rdata_o !== 32'h0000_0013) begin bad++; $display("FAIL rstw_next_rsp got=%b %h exp=1 00000013", ifu_rsp_valid_o, ifu_rdata_o); end
    tick;
    mem_rsp_valid_i = 0;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_contention;
    test_store_stall;
    test_spurious;
    test_reset_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
